// File: rtl/sipo_deser.sv
// sipo_deser: MSB-first serial-to-parallel deserializer with a one-deep valid/ready holding register
module sipo_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             data_in,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clear_ovr
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state, state_n;
  logic [WIDTH-2:0] shift_reg, shift_n;
  logic [CW-1:0]    bit_cnt, cnt_n;
  logic [WIDTH-1:0] word, par_out_n;
  logic             last, free, par_valid_n, overrun_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_out   <= '0;
      par_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_cnt   <= cnt_n;
      par_out   <= par_out_n;
      par_valid <= par_valid_n;
      overrun   <= overrun_n;
    end
  end
  always_comb begin
    word        = {shift_reg, data_in};
    last        = (state == SHIFT) && !start && (bit_cnt == LAST);
    free        = !par_valid || par_ready;
    state_n     = (start || (state == SHIFT && !last)) ? SHIFT : IDLE;
    shift_n     = start ? {{(WIDTH-2){1'b0}}, data_in} : (state == SHIFT) ? word[WIDTH-2:0] : shift_reg;
    cnt_n       = start ? CW'(1) : last ? '0 : (state == SHIFT) ? bit_cnt + CW'(1) : bit_cnt;
    par_out_n   = (last && free) ? word : par_out;
    par_valid_n = (last && free) ? 1'b1 : par_ready ? 1'b0 : par_valid;
    overrun_n   = (last && !free) ? 1'b1 : clear_ovr ? 1'b0 : overrun;
  end
  assign busy = (state == SHIFT);
endmodule
